// File: rtl/vx_pipe_flow_ctrl_pkg.sv
// Shared sizing helpers for the elastic pipeline controller.
package vx_pipe_flow_ctrl_pkg;

    // Occupancy counter width; a DEPTH=0 build still needs a 1-bit port.
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

    // Stage-enable vector width: one bit per stage, at least one bit.
    function automatic int unsigned en_width(input int unsigned depth);
        return (depth == 0) ? 1 : depth;
    endfunction

endpackage

// File: rtl/vx_pipe_flow_stage.sv
// One pipeline stage: a valid bit plus a payload register.
module vx_pipe_flow_stage #(
    parameter int unsigned DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    output logic [DATAW-1:0] data_out
);

    logic             valid_d, valid_q;
    logic [DATAW-1:0] data_d, data_q;

    // Flush overrides the load; payload is never cleared by flush.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (en) begin
            valid_d = valid_in;
        end
        if (en) begin
            data_d = data_in;
        end
    end

    // Stage state with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule

// File: rtl/vx_pipe_flow_ctrl.sv
// Elastic valid/ready controller for a DEPTH-stage register chain with bubble collapsing.
// With DEPTH=0 the block is a combinational pass-through and flush only gates ready_in.
module vx_pipe_flow_ctrl
    import vx_pipe_flow_ctrl_pkg::*;
#(
    parameter int unsigned DATAW = 1,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNTW  = occ_width(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       valid_in,
    input  logic [DATAW-1:0]           data_in,
    output logic                       ready_in,
    output logic                       valid_out,
    output logic [DATAW-1:0]           data_out,
    input  logic                       ready_out,
    output logic [en_width(DEPTH)-1:0] stage_en,
    output logic [CNTW-1:0]            occupancy,
    output logic                       busy
);

    if (DEPTH == 0) begin : g_bypass
        assign valid_out = valid_in;
        assign data_out  = data_in;
        assign ready_in  = ready_out && !flush;
        assign stage_en  = ready_out;
        assign occupancy = '0;
        assign busy      = 1'b0;
    end else begin : g_pipe
        logic [DEPTH:0]   en;
        logic [DEPTH-1:0] vld;
        logic [DATAW-1:0] dat [DEPTH];
        logic             push, pop;
        logic [CNTW-1:0]  occ_d, occ_q;

        // Enable ripples back from the consumer; an empty stage always loads.
        always_comb begin
            en[DEPTH] = ready_out;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                en[i] = !vld[i] || en[i+1];
            end
        end

        for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
            logic             s_vin;
            logic [DATAW-1:0] s_din;
            if (g == 0) begin : g_head
                assign s_vin = valid_in;
                assign s_din = data_in;
            end else begin : g_body
                assign s_vin = vld[g-1];
                assign s_din = dat[g-1];
            end
            vx_pipe_flow_stage #(
                .DATAW (DATAW)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .en        (en[g]),
                .flush     (flush),
                .valid_in  (s_vin),
                .data_in   (s_din),
                .valid_out (vld[g]),
                .data_out  (dat[g])
            );
        end

        assign stage_en  = en[DEPTH-1:0];
        assign ready_in  = en[0] && !flush;
        assign valid_out = vld[DEPTH-1];
        assign data_out  = dat[DEPTH-1];
        assign push      = valid_in && ready_in;
        assign pop       = valid_out && ready_out;

        // Occupancy follows accepts and pops; flush empties the chain.
        always_comb begin
            occ_d = occ_q + CNTW'(push) - CNTW'(pop);
            if (flush) begin
                occ_d = '0;
            end
        end

        // Occupancy counter register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;
        assign busy      = (occ_q != '0);

        a_hold_stalled: assert property (@(posedge clk) disable iff (reset)
            (valid_out && !ready_out && !flush) |=> $stable(data_out));
        a_occ_bound: assert property (@(posedge clk) disable iff (reset)
            occ_q <= CNTW'(DEPTH));
        a_occ_count: assert property (@(posedge clk) disable iff (reset)
            int'(occ_q) == $countones(vld));
    end

endmodule

// File: tb/tb_vx_pipe_flow_ctrl.sv
// Bench for vx_pipe_flow_ctrl: DEPTH=3 pipe against a queue model, plus a DEPTH=0 build.
module tb_vx_pipe_flow_ctrl;

    localparam int D  = 3;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush, valid_in, ready_out;
    logic [DW-1:0] data_in;
    logic          ready_in, valid_out, busy;
    logic [DW-1:0] data_out;
    logic [D-1:0]  stage_en;
    logic [1:0]    occupancy;

    logic          flush0, valid_in0, ready_out0;
    logic [DW-1:0] data_in0;
    logic          ready_in0, valid_out0, busy0;
    logic [DW-1:0] data_out0;
    logic [0:0]    stage_en0;
    logic [0:0]    occupancy0;

    vx_pipe_flow_ctrl #(.DATAW(DW), .DEPTH(D)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_out (ready_out),
        .stage_en  (stage_en),
        .occupancy (occupancy),
        .busy      (busy)
    );

    vx_pipe_flow_ctrl #(.DATAW(DW), .DEPTH(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush0),
        .valid_in  (valid_in0),
        .data_in   (data_in0),
        .ready_in  (ready_in0),
        .valid_out (valid_out0),
        .data_out  (data_out0),
        .ready_out (ready_out0),
        .stage_en  (stage_en0),
        .occupancy (occupancy0),
        .busy      (busy0)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: in-flight items oldest first, each with its stage position.
    logic [DW-1:0] mq_data[$];
    int            mq_pos[$];

    logic          cap_ready_in, cap_valid_out;
    logic [D-1:0]  cap_stage_en;
    logic [DW-1:0] cap_data_out;

    function automatic bit m_ready_in(bit fl, bit ro);
        return !fl && !((mq_pos.size() == D) && !ro);
    endfunction

    function automatic bit m_valid_out();
        return (mq_pos.size() > 0) && (mq_pos[0] == D - 1);
    endfunction

    // A stage loads unless it and everything after it is occupied and the consumer stalls.
    function automatic logic [D-1:0] m_stage_en(bit ro);
        logic [D-1:0] e;
        for (int i = 0; i < D; i++) begin
            int cnt;
            cnt = 0;
            foreach (mq_pos[k]) if (mq_pos[k] >= i) cnt++;
            e[i] = !((cnt == D - i) && !ro);
        end
        return e;
    endfunction

    // Advance each item one slot, never past the slot its predecessor ends up in.
    task automatic model_edge(input bit vi, input logic [DW-1:0] di, input bit fl, input bit ro);
        bit acc;
        int prev;
        acc = vi && m_ready_in(fl, ro);
        if (fl) begin
            mq_data.delete();
            mq_pos.delete();
            return;
        end
        if (m_valid_out() && ro) begin
            void'(mq_data.pop_front());
            void'(mq_pos.pop_front());
        end
        prev = D;
        foreach (mq_pos[k]) begin
            int np;
            np = mq_pos[k] + 1;
            if (np > prev - 1) np = prev - 1;
            mq_pos[k] = np;
            prev = np;
        end
        if (acc) begin
            mq_data.push_back(di);
            mq_pos.push_back(0);
        end
    endtask

    task automatic cycle(input bit vi, input logic [DW-1:0] di, input bit fl, input bit ro);
        valid_in  = vi;
        data_in   = di;
        flush     = fl;
        ready_out = ro;
        @(negedge clk);
        cap_ready_in  = ready_in;
        cap_stage_en  = stage_en;
        cap_valid_out = valid_out;
        cap_data_out  = data_out;
        @(posedge clk);
        model_edge(vi, di, fl, ro);
        #1;
    endtask

    task automatic do_reset();
        valid_in  = 1'b0;
        data_in   = '0;
        flush     = 1'b0;
        ready_out = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mq_data.delete();
        mq_pos.delete();
    endtask

    task automatic test_reset();
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got %h want 00", data_out); end
        n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (ready_in !== 1'b1) begin n_fail++; $display("FAIL rst_ready_in: got %b want 1", ready_in); end
        n_cmp++; if (stage_en !== 3'b111) begin n_fail++; $display("FAIL rst_stage_en: got %b want 111", stage_en); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        logic [DW-1:0] exp_d [6];
        logic          exp_v [6];
        int            exp_occ [6];
        exp_d   = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        exp_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_occ = '{1, 2, 3, 2, 1, 0};
        for (int k = 0; k < 6; k++) begin
            logic [DW-1:0] d;
            d = 8'hA1 + 8'(k);
            cycle(k < 3, d, 1'b0, 1'b1);
            n_cmp++; if (valid_out !== exp_v[k]) begin n_fail++; $display("FAIL lat_valid_out[%0d]: got %b want %b", k, valid_out, exp_v[k]); end
            if (exp_v[k]) begin
                n_cmp++; if (data_out !== exp_d[k]) begin n_fail++; $display("FAIL lat_data_out[%0d]: got %h want %h", k, data_out, exp_d[k]); end
            end
            n_cmp++; if (int'(occupancy) !== exp_occ[k]) begin n_fail++; $display("FAIL lat_occupancy[%0d]: got %0d want %0d", k, occupancy, exp_occ[k]); end
        end
    endtask

    task automatic test_stall();
        int acc;
        acc = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'hB1 + 8'(k), 1'b0, 1'b0);
            if (cap_ready_in) acc++;
            if (k >= 3) begin
                n_cmp++; if (cap_ready_in !== 1'b0) begin n_fail++; $display("FAIL stall_ready_in[%0d]: got %b want 0", k, cap_ready_in); end
            end
        end
        n_cmp++; if (acc !== 3) begin n_fail++; $display("FAIL stall_accepted: got %0d want 3", acc); end
        n_cmp++; if (data_out !== 8'hB1) begin n_fail++; $display("FAIL stall_data_out: got %h want b1", data_out); end
        n_cmp++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL stall_occupancy: got %0d want 3", occupancy); end
        n_cmp++; if (stage_en !== 3'b000) begin n_fail++; $display("FAIL stall_stage_en: got %b want 000", stage_en); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [4];
        exp_d = '{8'hB1, 8'hB2, 8'hB3, 8'hC1};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 8'hC1 + 8'(k), 1'b0, 1'b1);
            n_cmp++; if (cap_ready_in !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in[%0d]: got %b want 1", k, cap_ready_in); end
            n_cmp++; if (cap_data_out !== exp_d[k] || cap_valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b_data_out[%0d]: got %b/%h want 1/%h", k, cap_valid_out, cap_data_out, exp_d[k]); end
            n_cmp++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL b2b_occupancy[%0d]: got %0d want 3", k, occupancy); end
        end
    endtask

    task automatic test_bubble();
        logic [DW-1:0] exp_d [3];
        int            en0_low;
        exp_d   = '{8'h10, 8'h20, 8'h30};
        en0_low = 0;
        do_reset();
        cycle(1'b1, 8'h10, 1'b0, 1'b0); if (!cap_stage_en[0]) en0_low++;
        cycle(1'b0, 8'h00, 1'b0, 1'b0); if (!cap_stage_en[0]) en0_low++;
        cycle(1'b1, 8'h20, 1'b0, 1'b0); if (!cap_stage_en[0]) en0_low++;
        cycle(1'b0, 8'h00, 1'b0, 1'b0); if (!cap_stage_en[0]) en0_low++;
        n_cmp++; if (stage_en !== 3'b001) begin n_fail++; $display("FAIL bub_stage_en: got %b want 001", stage_en); end
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bub_occupancy: got %0d want 2", occupancy); end
        cycle(1'b1, 8'h30, 1'b0, 1'b0); if (!cap_stage_en[0]) en0_low++;
        n_cmp++; if (en0_low !== 0) begin n_fail++; $display("FAIL bub_en0_low: got %0d want 0", en0_low); end
        n_cmp++; if (stage_en !== 3'b000) begin n_fail++; $display("FAIL bub_stage_en_full: got %b want 000", stage_en); end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            n_cmp++; if (cap_valid_out !== 1'b1 || cap_data_out !== exp_d[k]) begin n_fail++; $display("FAIL bub_drain[%0d]: got %b/%h want 1/%h", k, cap_valid_out, cap_data_out, exp_d[k]); end
        end
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        do_reset();
        cycle(1'b1, 8'hD1, 1'b0, 1'b0);
        cycle(1'b1, 8'hD2, 1'b0, 1'b0);
        n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL fl_pre_occupancy: got %0d want 2", occupancy); end
        cycle(1'b1, 8'hDE, 1'b1, 1'b0);
        n_cmp++; if (cap_ready_in !== 1'b0) begin n_fail++; $display("FAIL fl_ready_in: got %b want 0", cap_ready_in); end
        n_cmp++; if (occupancy !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL fl_occupancy: got %0d/%b want 0/0", occupancy, busy); end
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL fl_valid_out: got %b want 0", valid_out); end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (cap_valid_out) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL fl_emitted: got %0d want 0", seen); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1'b1, 8'hE1 + 8'(k), 1'b0, 1'b0);
        valid_in = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL ar_valid_out: got %b want 0", valid_out); end
        n_cmp++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL ar_data_out: got %h want 00", data_out); end
        n_cmp++; if (occupancy !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL ar_occupancy: got %0d/%b want 0/0", occupancy, busy); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mq_data.delete();
        mq_pos.delete();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit            vi, fl, ro;
            logic [DW-1:0] di;
            vi = ($urandom_range(0, 3) != 0);
            di = 8'($urandom);
            fl = ($urandom_range(0, 24) == 0);
            ro = (k < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            valid_in  = vi;
            data_in   = di;
            flush     = fl;
            ready_out = ro;
            @(negedge clk);
            n_cmp++; if (ready_in !== m_ready_in(fl, ro)) begin n_fail++; $display("FAIL rnd_ready_in[%0d]: got %b want %b", k, ready_in, m_ready_in(fl, ro)); end
            n_cmp++; if (stage_en !== m_stage_en(ro)) begin n_fail++; $display("FAIL rnd_stage_en[%0d]: got %b want %b", k, stage_en, m_stage_en(ro)); end
            n_cmp++; if (valid_out !== m_valid_out()) begin n_fail++; $display("FAIL rnd_valid_out[%0d]: got %b want %b", k, valid_out, m_valid_out()); end
            if (m_valid_out()) begin
                n_cmp++; if (data_out !== mq_data[0]) begin n_fail++; $display("FAIL rnd_data_out[%0d]: got %h want %h", k, data_out, mq_data[0]); end
            end
            n_cmp++; if (int'(occupancy) !== mq_pos.size()) begin n_fail++; $display("FAIL rnd_occupancy[%0d]: got %0d want %0d", k, occupancy, mq_pos.size()); end
            n_cmp++; if (busy !== (mq_pos.size() != 0)) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want %b", k, busy, mq_pos.size() != 0); end
            @(posedge clk);
            model_edge(vi, di, fl, ro);
            #1;
        end
    endtask

    task automatic test_depth0();
        for (int k = 0; k < 16; k++) begin
            bit            vi, fl, ro;
            logic [DW-1:0] di;
            vi = 1'($urandom);
            fl = 1'($urandom);
            ro = 1'($urandom);
            di = 8'($urandom);
            valid_in0  = vi;
            data_in0   = di;
            flush0     = fl;
            ready_out0 = ro;
            #1;
            n_cmp++; if (valid_out0 !== vi || data_out0 !== di) begin n_fail++; $display("FAIL d0_pass[%0d]: got %b/%h want %b/%h", k, valid_out0, data_out0, vi, di); end
            n_cmp++; if (ready_in0 !== (ro && !fl)) begin n_fail++; $display("FAIL d0_ready_in[%0d]: got %b want %b", k, ready_in0, ro && !fl); end
            n_cmp++; if (stage_en0 !== 1'(ro) || occupancy0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL d0_status[%0d]: got %b/%0d/%b want %b/0/0", k, stage_en0, occupancy0, busy0, ro); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        ready_out  = 1'b0;
        flush0     = 1'b0;
        valid_in0  = 1'b0;
        data_in0   = '0;
        ready_out0 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_stall();
        test_back_to_back();
        test_bubble();
        test_flush();
        test_async_reset();
        test_random();
        test_depth0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
